control_sequencer: RTL

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/control_sequencer.sv
// ---------------------------------------------------------------------------
// control_sequencer
//   Turns asynchronous tone-request buttons into a sequence of tones for the
//   tone datapath. Each request plays until the datapath reports done, or
//   until the watchdog aborts it. A fixed silent gap always follows a tone.
//   One further request can wait in a single pending slot. Requests that
//   find no room are discarded and recorded in a sticky flag.
//
// Ports
//   clk          in   system clock; all state changes on the rising edge
//   rst          in   asynchronous active-low reset
//   btn[2:0]     in   async buttons: bit2 = tone A, bit1 = B, bit0 = C
//   done         in   tone finished (sampled only while a tone plays)
//   cv[2:0]      out  one-hot tone select {A,B,C}; 000 = silent
//   busy         out  high whenever the sequencer is not idle
//   timeout      out  one-cycle pulse after a watchdog abort
//   last_tone    out  last ended tone: 0 none, 1 C, 2 B, 3 A
//   played_count out  tones ended by done, wraps 255 -> 0
//   dropped      out  sticky: a request was discarded
//   state_dbg    out  current FSM state (IDLE=0, PLAY=1, GAP=2)
//
// Handshake: there is no valid/ready pair on this block. A request is the
//   rising edge of a synchronised button bit and is accepted, queued or
//   dropped in the cycle it is seen. done is a level sampled on every
//   rising edge while a tone plays and is ignored in every other state.
// ---------------------------------------------------------------------------
module control_sequencer #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd16777215,
  parameter logic [15:0] GAP_CYCLES     = 16'd1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] btn,
  input  logic       done,
  output logic [2:0] cv,
  output logic       busy,
  output logic       timeout,
  output logic [1:0] last_tone,
  output logic [7:0] played_count,
  output logic       dropped,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  sync1_q, sync2_q, hist_q;
  logic [2:0]  tone_q, tone_d;
  logic [2:0]  pend_q, pend_d;
  logic        pend_valid_q, pend_valid_d;
  logic [23:0] wd_q, wd_d;
  logic [15:0] gap_q, gap_d;
  logic        timeout_q, timeout_d;
  logic [1:0]  last_q, last_d;
  logic [7:0]  count_q, count_d;
  logic        dropped_q, dropped_d;

  logic [2:0]  press;
  logic [2:0]  winner;

  function automatic logic [1:0] tone_code(input logic [2:0] t);
    if (t[2])      tone_code = 2'd3;
    else if (t[1]) tone_code = 2'd2;
    else if (t[0]) tone_code = 2'd1;
    else           tone_code = 2'd0;
  endfunction

  // A press is the first cycle a synchronised bit is seen high; holding a
  // button does not repeat the request.
  assign press  = sync2_q & ~hist_q;
  assign winner = press[2] ? 3'b100 :
                  press[1] ? 3'b010 :
                  press[0] ? 3'b001 : 3'b000;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      sync1_q      <= 3'b000;
      sync2_q      <= 3'b000;
      hist_q       <= 3'b000;
      tone_q       <= 3'b000;
      pend_q       <= 3'b000;
      pend_valid_q <= 1'b0;
      wd_q         <= 24'd0;
      gap_q        <= 16'd0;
      timeout_q    <= 1'b0;
      last_q       <= 2'd0;
      count_q      <= 8'd0;
      dropped_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= btn;
      sync2_q      <= sync1_q;
      hist_q       <= sync2_q;
      tone_q       <= tone_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      wd_q         <= wd_d;
      gap_q        <= gap_d;
      timeout_q    <= timeout_d;
      last_q       <= last_d;
      count_q      <= count_d;
      dropped_q    <= dropped_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    tone_d       = tone_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    wd_d         = wd_q;
    gap_d        = gap_q;
    timeout_d    = 1'b0;
    last_d       = last_q;
    count_d      = count_q;
    // Lower-priority presses in the same cycle as the winner are always lost.
    dropped_d    = dropped_q | (|(press & ~winner));

    case (state_q)
      IDLE: begin
        if (|winner) begin
          state_d = PLAY;
          tone_d  = winner;
          wd_d    = 24'd0;
        end
      end

      PLAY: begin
        if (|winner) begin
          if (pend_valid_q) begin
            dropped_d = 1'b1;
          end else begin
            pend_d       = winner;
            pend_valid_d = 1'b1;
          end
        end
        // done wins over a watchdog expiry in the same cycle.
        if (done) begin
          state_d = GAP;
          gap_d   = 16'd0;
          count_d = count_q + 8'd1;
          last_d  = tone_code(tone_q);
        end else if (wd_q == TIMEOUT_CYCLES - 24'd1) begin
          state_d   = GAP;
          gap_d     = 16'd0;
          timeout_d = 1'b1;
          last_d    = tone_code(tone_q);
        end else begin
          wd_d = wd_q + 24'd1;
        end
      end

      GAP: begin
        if (gap_q == GAP_CYCLES - 16'd1) begin
          // Last silent cycle. The slot is still occupied during this cycle,
          // so a fresh press here is lost if a request is already waiting;
          // with an empty slot the fresh press starts straight away.
          if (pend_valid_q) begin
            state_d      = PLAY;
            tone_d       = pend_q;
            pend_d       = 3'b000;
            pend_valid_d = 1'b0;
            wd_d         = 24'd0;
            if (|winner) dropped_d = 1'b1;
          end else if (|winner) begin
            state_d = PLAY;
            tone_d  = winner;
            wd_d    = 24'd0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_d = gap_q + 16'd1;
          if (|winner) begin
            if (pend_valid_q) begin
              dropped_d = 1'b1;
            end else begin
              pend_d       = winner;
              pend_valid_d = 1'b1;
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode directly from registers so reset silences them at once.
  assign cv           = (state_q == PLAY) ? tone_q : 3'b000;
  assign busy         = (state_q != IDLE);
  assign timeout      = timeout_q;
  assign last_tone    = last_q;
  assign played_count = count_q;
  assign dropped      = dropped_q;
  assign state_dbg    = state_q;

endmodule
